// File: rtl/shift_counter_gen.sv
// shift_counter_gen: one-hot ring / Johnson shift counter with load, illegal-state correction and wrap pulse
module shift_counter_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);
  logic             mode_q;
  logic [WIDTH-1:0] home, nxt, inv;
  logic             ring_ok, john_ok, legal;
  always_comb begin
    home    = {{(WIDTH-1){1'b0}}, ~mode};
    inv     = ~count;
    ring_ok = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
    john_ok = ((count & (count + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
    legal   = mode ? john_ok : ring_ok;
    // Johnson differs from ring only by inverting the bit fed back into the vacated end
    nxt     = dir ? {count[0] ^ mode, count[WIDTH-1:1]} : {count[WIDTH-2:0], count[WIDTH-1] ^ mode};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= WIDTH'(1);
      mode_q <= 1'b0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else if (load) begin
      count  <= load_val;
      mode_q <= mode;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else if (mode != mode_q) begin
      count  <= home;
      mode_q <= mode;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else if (!legal) begin
      count <= home;
      wrap  <= 1'b0;
      err   <= 1'b1;
    end else if (en) begin
      count <= nxt;
      wrap  <= (nxt == home);
      err   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_counter_gen.sv
// tb_shift_counter_gen: directed vectors for the 4-bit ring/Johnson counter
module tb_shift_counter_gen;
  logic       clk = 1'b0;
  logic       rst, en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       wrap, err;
  int         vecs = 0;
  int         miss = 0;
  shift_counter_gen #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got wrap/err/count=%b/%b/%b expected %b/%b/%b",
               tag, got[5], got[4], got[3:0], exp[5], exp[4], exp[3:0]);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic e, input logic m, input logic d,
                      input logic l, input logic [3:0] lv, input logic [3:0] ec,
                      input logic ew, input logic ee);
    rst = r; en = e; mode = m; dir = d; load = l; load_val = lv;
    @(posedge clk);
    #1;
    chk(tag, {wrap, err, count}, {ew, ee, ec});
  endtask
  initial begin
    logic [3:0] ring_l [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_l [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] john_r [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    step("reset", 1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0);
    for (int i = 0; i < 8; i++)
      step("ring_left", 0, 1, 0, 0, 0, 4'b0000, ring_l[i], ring_l[i] == 4'b0001, 0);
    step("mode_to_johnson", 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 8; i++)
      step("johnson_left", 0, 1, 1, 0, 0, 4'b0000, john_l[i], i == 7, 0);
    for (int i = 0; i < 8; i++)
      step("johnson_right", 0, 1, 1, 1, 0, 4'b0000, john_r[i], i == 7, 0);
    step("j_load_bad", 0, 0, 1, 0, 1, 4'b0101, 4'b0101, 0, 0);
    step("j_fix_bad", 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1);
    step("j_load_ok", 0, 0, 1, 0, 1, 4'b1100, 4'b1100, 0, 0);
    step("j_adv_ok", 0, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 0);
    step("r_load_bad", 0, 0, 0, 0, 1, 4'b0110, 4'b0110, 0, 0);
    step("r_fix_bad", 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1);
    step("r_err_clear", 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0);
    step("r_load_zero", 0, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 0);
    step("r_fix_zero_en", 0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0, 1);
    step("r_load_ok", 0, 0, 0, 0, 1, 4'b0100, 4'b0100, 0, 0);
    step("r_hold", 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 0, 0);
    step("dir_toggle0", 0, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, 0);
    step("dir_toggle1", 0, 1, 0, 1, 0, 4'b0000, 4'b0100, 0, 0);
    step("dir_toggle2", 0, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, 0);
    step("dir_hold", 0, 0, 0, 1, 0, 4'b0000, 4'b1000, 0, 0);
    step("to_johnson", 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    step("johnson_mid", 0, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, 0);
    step("rst_over_load", 1, 1, 1, 0, 1, 4'b0101, 4'b0001, 0, 0);
    step("post_rst_home", 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    step("post_rst_adv", 0, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/shift_counter_gen.md
# shift_counter_gen

Parametrised one-hot ring / Johnson (twisted-ring) shift counter with run-time mode and direction select, enable, parallel load, illegal-state self-correction and a wrap pulse. Generational successor to the fixed 4-bit left-rotating ring counter in the sequential counters library. Used as a sequence/phase generator for state decoding, LED chasers and multi-phase strobe generation.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; counter holds when low.
- mode  input  1  0 = ring (one-hot rotate), 1 = Johnson (shift with inverted feedback).
- dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value written on load.
- count  output  WIDTH  registered counter state.
- wrap  output  1  registered one-cycle pulse: advance landed on home state.
- err  output  1  registered one-cycle pulse: illegal state was corrected.

## Operation
- Home state: ring = LSB set only (0..01); Johnson = all zeros.
- Advance, ring: left count <= {count[W-2:0], count[W-1]}; right count <= {count[0], count[W-1:1]}.
- Advance, Johnson: left count <= {count[W-2:0], ~count[W-1]}; right count <= {~count[0], count[W-1:1]}.
- Sequence length: ring WIDTH states; Johnson 2*WIDTH states.
- Legal states, ring: exactly one bit set. Johnson: bits 0 and up set contiguously with all remaining bits clear (0..01..1, incl. all zeros), or bits 0 and up clear contiguously with all remaining bits set (1..10..0, incl. all ones). Same set for both directions.
- Internal mode_q register holds mode of the previous cycle.
- Per-edge priority (highest first):
  - rst: count = home(ring) = 0..01, mode_q = 0, wrap = 0, err = 0.
  - load: count = load_val verbatim (no legality check this cycle), mode_q = mode, wrap = 0, err = 0.
  - mode != mode_q: count = home(mode), mode_q = mode, wrap = 0, err = 0.
  - count illegal for mode: count = home(mode), err = 1, wrap = 0. Applies regardless of en.
  - en = 1: advance per mode/dir; wrap = 1 iff new count == home(mode); err = 0.
  - otherwise: hold count; wrap = 0, err = 0.
- dir may change on any cycle; takes effect on the next advance with no correction.
- Illegal value loaded: held one cycle, corrected on the following edge with err pulse.

## Timing
- All outputs registered; no combinational input-to-output path.
- Advance latency: one clock; count updates on the edge where en sampled high.
- wrap and err are aligned with the count value they describe (same cycle), width exactly one cycle unless the condition recurs on the next edge.
- WIDTH = 2 Johnson: 4 states (00, 01, 11, 10 left); ring: 01, 10 alternate with wrap every second advance.
- Reset mid-sequence: next cycle count = 0..01 regardless of mode, en, load; if mode = 1, one further edge forces Johnson home (0000) with no err.
- rst and load both high: rst wins. load and mode change both: load wins, mode_q updated.

## Test plan
- WIDTH=4, rst then mode=0, dir=0, en=1 for 8 cycles -> count 0010, 0100, 1000, 0001 (wrap=1), 0010, ... wrap high only on 0001.
- WIDTH=4, mode=1, dir=0, en=1 -> first edge count 0000 (mode change, no wrap), then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 (wrap=1); repeat with dir=1 -> 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
- Ring, load=1 load_val=0110, en=0 -> count 0110, next edge count 0001 with err=1 for one cycle; load 0100 -> no err, holds while en=0.
- Johnson, load 0101 -> next edge 0000 with err=1; load 1100 -> legal, advances left to 1000 with no err.
- Ring at 0100, en=1, toggle dir each cycle -> 1000, 0100, 1000, ...; no wrap, no err; en=0 holds value.
- Mid-sequence rst with load=1 and mode=1 -> count 0001; following edge (rst low, load low) count 0000, err=0, wrap=0.
